// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps one read in flight to
// instruction memory and holds the selected 32-bit word for decode.
module ifu_fetch #(
    parameter int unsigned       ADDR_W = 64,
    parameter logic [ADDR_W-1:0] PC_RST = ADDR_W'(64'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              resp_valid,
    input  logic [63:0]       resp_data,
    input  logic              resp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [63:0]       fetch_cnt
);

    localparam int unsigned INST_W = 32;
    localparam int unsigned CNT_W  = 64;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic                drop_q;
    logic                req_valid_q;
    logic                inst_valid_q;
    logic [INST_W-1:0]   inst_q;
    logic [ADDR_W-1:0]   inst_pc_q;
    logic                inst_fault_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [ADDR_W-1:0]   redir_pc_c;
    logic [INST_W-1:0]   sel_word_c;

    // Redirect target with the low two bits forced to zero.
    assign redir_pc_c = redirect_pc & ~ADDR_W'(3);

    // Pick the half of the doubleword addressed by pc[2].
    assign sel_word_c = pc_q[2] ? resp_data[63:32] : resp_data[31:0];

    // Fetch FSM: request, wait for the beat, hold it until decode takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_REQ;
            pc_q         <= PC_RST;
            drop_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_REQ: begin
                    // req_valid comes up one edge after reset release.
                    req_valid_q <= 1'b1;
                    if (redirect_valid) begin
                        pc_q <= redir_pc_c;
                    end
                    if (req_valid_q && req_ready) begin
                        // A redirect racing the accept makes that read stale.
                        state_q     <= S_WAIT;
                        req_valid_q <= 1'b0;
                        drop_q      <= redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (resp_valid) begin
                        if (redirect_valid || drop_q) begin
                            if (redirect_valid) begin
                                pc_q <= redir_pc_c;
                            end
                            drop_q      <= 1'b0;
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                        end else begin
                            inst_q       <= resp_err ? '0 : sel_word_c;
                            inst_pc_q    <= pc_q;
                            inst_fault_q <= resp_err;
                            state_q      <= S_HOLD;
                            inst_valid_q <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        pc_q   <= redir_pc_c;
                        drop_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || inst_ready) begin
                        pc_q         <= redirect_valid ? redir_pc_c : pc_q + ADDR_W'(4);
                        state_q      <= S_REQ;
                        req_valid_q  <= 1'b1;
                        inst_valid_q <= 1'b0;
                        if (inst_ready) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q      <= S_REQ;
                    req_valid_q  <= 1'b1;
                    inst_valid_q <= 1'b0;
                    drop_q       <= 1'b0;
                end
            endcase
        end
    end

    assign req_valid  = req_valid_q;
    assign req_addr   = {pc_q[ADDR_W-1:3], 3'b000};
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = inst_fault_q;
    assign fetch_cnt  = cnt_q;

    // A response beat is only legal while a read is outstanding.
    resp_in_wait_a: assert property (@(posedge clk) disable iff (!rst)
        resp_valid |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized scoreboard bench for ifu_fetch: memory responder, redirect/decode
// driver, and a monitor comparing delivered instructions to an expected stream.
module tb_ifu_fetch;

    localparam logic [63:0] PC_RST = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] fetch_cnt;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_cnt      (fetch_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Stimulus knobs
    int unsigned rr_pct, ir_pct, redir_pct, lat_min, lat_max;

    // Expected stream of instruction PCs; front is the next one decode should see
    logic [63:0] exp_q[$];
    logic [63:0] tb_cnt;
    int          n_deliv = 0;
    int          idle = 0;
    bit          chk_first = 1'b0;

    // Responder state
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [63:0] acc_addr = '0;

    function automatic logic [63:0] mem_dword(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h00100093_00000413;
        return {a[31:0] ^ a[63:32] ^ 32'h1357_9BDF, (a[31:0] * 32'h9E37_79B1) + 32'h0246_8ACE};
    endfunction

    function automatic logic mem_err(input logic [63:0] a);
        return a[6:3] == 4'hB;
    endfunction

    function automatic logic [31:0] exp_word(input logic [63:0] pc);
        logic [63:0] d;
        logic [63:0] al;
        al = {pc[63:3], 3'b000};
        d  = mem_dword(al);
        if (mem_err(al)) return 32'h0;
        return pc[2] ? d[63:32] : d[31:0];
    endfunction

    function automatic logic [63:0] rand_target();
        int unsigned sel;
        sel = $urandom_range(0, 99);
        if (sel < 70)
            return 64'h8000_0000 + 64'($urandom_range(0, 511)) * 64'd4 + 64'($urandom_range(0, 3));
        else if (sel < 85)
            return 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 31));
        return {$urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic issue_redirect(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        exp_q.push_back(pc & ~64'h3);
    endtask

    // Randomized decode/redirect driver for n cycles
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            inst_ready = ($urandom_range(0, 99) < ir_pct);
            if ($urandom_range(0, 99) < redir_pct) issue_redirect(rand_target());
            else redirect_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    // Wait (bounded) until a read is in flight; resp_now picks the cycle its beat lands
    task automatic wait_pend(input bit resp_now);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge clk);
            #1;
            if (pend && (resp_now ? (cnt == 0) : (cnt >= 1))) found = 1'b1;
        end
        if (!found) fail_now("wait_pend_timeout");
    endtask

    // Memory responder: random req_ready, one beat after a random latency
    initial begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend       = 1'b0;
                cnt        = 0;
                resp_valid = 1'b0;
                resp_err   = 1'b0;
                req_ready  = 1'b0;
            end else begin
                resp_valid = 1'b0;
                resp_err   = 1'b0;
                if (pend) begin
                    chk("one_outstanding", {63'd0, req_valid}, 64'd0);
                    if (cnt == 0) begin
                        resp_valid = 1'b1;
                        resp_data  = mem_dword(acc_addr);
                        resp_err   = mem_err(acc_addr);
                        pend       = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                req_ready = ($urandom_range(0, 99) < rr_pct);
                if (req_valid && req_ready) begin
                    chk("req_align", {61'd0, req_addr[2:0]}, 64'd0);
                    if (chk_first) begin
                        chk("first_req_addr", req_addr, PC_RST);
                        chk_first = 1'b0;
                    end
                    acc_addr = req_addr;
                    pend     = 1'b1;
                    cnt      = int'($urandom_range(lat_min - 1, lat_max - 1));
                end
            end
        end
    end

    // Monitor: compare presented instruction to expected front, pop on handshake
    logic [63:0] mon_e;
    bit          mon_have;
    always @(negedge clk) begin
        if (!rst) begin
            idle = 0;
        end else begin
            mon_have = (exp_q.size() > 0);
            mon_e    = mon_have ? exp_q[0] : 64'd0;
            if (inst_valid) begin
                if (!mon_have) begin
                    fail_now("unexpected_inst");
                end else begin
                    chk("inst_pc", inst_pc, mon_e);
                    chk("inst", {32'd0, inst}, {32'd0, exp_word(mon_e)});
                    chk("inst_fault", {63'd0, inst_fault}, {63'd0, mem_err({mon_e[63:3], 3'b000})});
                end
                chk("req_while_hold", {63'd0, req_valid}, 64'd0);
            end
            if (inst_valid && inst_ready) begin
                chk("fetch_cnt", fetch_cnt, tb_cnt);
                if (mon_have) void'(exp_q.pop_front());
                tb_cnt = tb_cnt + 64'd1;
                n_deliv++;
                idle = 0;
                if (!redirect_valid && mon_have) exp_q.push_back(mon_e + 64'd4);
            end else begin
                idle++;
            end
            if (redirect_valid) begin
                while (exp_q.size() > 1) void'(exp_q.pop_front());
            end
            if (idle > 300) begin
                fail_now("no_progress");
                idle = 0;
            end
        end
    end

    int d0;
    initial begin
        rst            = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rr_pct = 100; ir_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 1;
        tb_cnt = '0;
        exp_q.push_back(PC_RST);

        #1;
        chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_inst", {32'd0, inst}, 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_inst_fault", {63'd0, inst_fault}, 64'd0);
        chk("rst_fetch_cnt", fetch_cnt, 64'd0);

        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        chk_first = 1'b1;
        #1 chk("req_valid_pre_edge", {63'd0, req_valid}, 64'd0);
        @(posedge clk);
        #1 chk("req_valid_rise", {63'd0, req_valid}, 64'd1);
        inst_ready = 1'b1;

        // First fetches and best-case throughput
        run(12);
        d0 = n_deliv;
        run(29);
        chk("throughput", 64'(n_deliv - d0), 64'd10);
        chk("fetch_cnt_run", fetch_cnt, tb_cnt);

        // Decode backpressure
        ir_pct = 0;
        run(6);
        chk("bp_inst_valid", {63'd0, inst_valid}, 64'd1);
        chk("bp_req_valid", {63'd0, req_valid}, 64'd0);
        ir_pct = 100;
        run(9);

        // Redirect while the read is in flight, old beat arrives later
        lat_min = 3; lat_max = 3;
        wait_pend(1'b0);
        issue_redirect(64'h8000_0100);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        run(15);

        // Redirect in the same cycle as the beat
        lat_min = 1; lat_max = 1;
        wait_pend(1'b1);
        issue_redirect(64'h8000_0200);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        run(15);

        // Faulting doubleword, then PC wrap
        issue_redirect(64'h8000_0058);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        run(15);
        issue_redirect(64'hFFFF_FFFF_FFFF_FFFA);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        run(18);

        // Asynchronous reset while waiting for a beat
        lat_min = 3; lat_max = 3;
        wait_pend(1'b0);
        #2 rst = 1'b0;
        #1;
        chk("arst_req_valid", {63'd0, req_valid}, 64'd0);
        chk("arst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("arst_fetch_cnt", fetch_cnt, 64'd0);
        exp_q.delete();
        exp_q.push_back(PC_RST);
        tb_cnt = '0;
        redirect_valid = 1'b0;
        lat_min = 1; lat_max = 1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        chk_first = 1'b1;
        run(15);

        // Randomized phases
        for (int p = 0; p < 6; p++) begin
            rr_pct    = $urandom_range(30, 100);
            ir_pct    = $urandom_range(20, 100);
            redir_pct = $urandom_range(0, 15);
            lat_min   = 1;
            lat_max   = $urandom_range(1, 4);
            run(1500);
        end
        redir_pct = 0; ir_pct = 100; rr_pct = 100;
        run(40);
        chk("fetch_cnt_end", fetch_cnt, tb_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Owns the architectural fetch PC and issues one outstanding read at a time to the instruction memory port over a valid/ready request channel and a valid response channel.
- Selects the 32-bit instruction from the 64-bit response beat and holds it, with its PC, on a valid/ready handshake until decode accepts it.
- Accepts redirects (jal, branches, reset vector) from execute and discards any in-flight stale response.

Parameters:
- PC_RST, 64'h80000000, PC value loaded on reset.
- ADDR_W, 64, PC and memory address width.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- req_valid  out  1  memory read request valid.
- req_ready  in  1  memory accepts request this cycle.
- req_addr  out  ADDR_W  doubleword-aligned address, equal to {pc[63:3],3'b000}.
- resp_valid  in  1  read data returned; single beat.
- resp_data  in  64  read doubleword.
- resp_err  in  1  access fault, qualified by resp_valid.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst  out  32  instruction word.
- inst_pc  out  ADDR_W  PC of inst.
- inst_fault  out  1  inst came from an errored response; inst is 0 in that case.
- redirect_valid  in  1  load new PC.
- redirect_pc  in  ADDR_W  target; bits [1:0] are ignored and treated as 0.
- fetch_cnt  out  64  count of instructions handed to decode.

Behaviour:
- The FSM has three states: S_REQ, S_WAIT and S_HOLD. The internal pc register is ADDR_W wide. A drop flag marks a stale response.
- Reset (rst=0, asynchronous) sets:
  - state=S_REQ, pc=PC_RST, drop=0, fetch_cnt=0;
  - inst=0, inst_pc=0, inst_fault=0.
- Outputs while in reset: req_valid=0, inst_valid=0. req_valid rises on the first posedge after rst deasserts.
- Outputs by state:
  - req_valid=1 only in S_REQ.
  - inst_valid=1 only in S_HOLD.
  - req_addr is always derived from the current pc.
- S_REQ:
  - req_ready=1 → S_WAIT.
  - redirect_valid=1 in the same cycle as req_ready=1: pc<=redirect_pc, drop<=1, → S_WAIT.
  - redirect_valid=1 with req_ready=0: pc<=redirect_pc, stay in S_REQ. req_addr changes while unaccepted; the memory side tolerates this.
- S_WAIT:
  - resp_valid=1, drop=0, no redirect:
    - inst<=pc[2] ? resp_data[63:32] : resp_data[31:0];
    - inst_pc<=pc, inst_fault<=resp_err;
    - if resp_err=1, inst<=0;
    - → S_HOLD.
  - resp_valid=1 with drop=1: the response is discarded, drop<=0, → S_REQ.
  - redirect_valid=1 without resp_valid: pc<=redirect_pc, drop<=1, stay in S_WAIT.
  - redirect_valid=1 with resp_valid=1: the response is discarded, pc<=redirect_pc, drop<=0, → S_REQ.
- S_HOLD:
  - inst, inst_pc and inst_fault remain stable until handshake completion.
  - inst_ready=1 without redirect: pc<=pc+4 (wraps modulo 2^ADDR_W), fetch_cnt<=fetch_cnt+1, → S_REQ.
  - redirect_valid=1 (with or without inst_ready): pc<=redirect_pc, → S_REQ. fetch_cnt increments only if inst_ready=1. Redirect has priority over sequential increment.
- Only one request is outstanding at a time. No new request is issued while in S_WAIT.
- Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD), with req_ready=1, 1-cycle response and inst_ready=1.
- Redirect latency: the redirected req_addr appears on req_addr in the cycle after the redirect is sampled.
- The fetch_cnt counter wraps at 2^64.
- resp_valid outside S_WAIT is a protocol violation. It is ignored, and an assertion fires in simulation.

Test Plan:
- Reset/first fetch: hold rst=0 for 3 cycles then release; req_ready=1, resp one cycle later with data 64'h00100093_00000413 → first req_addr=0x80000000, inst=0x00000413 at inst_pc=0x80000000. Next: req_addr=0x80000000 again, inst=0x00100093 at inst_pc=0x80000004, fetch_cnt=2.
- Backpressure: inst_ready=0 for 5 cycles in S_HOLD → inst and inst_pc stable, req_valid=0. Then assert inst_ready → the next request goes to pc+4.
- Redirect in S_WAIT: after request 0x80000008 is accepted, assert redirect_pc=0x80000100; the old response arrives 2 cycles later → old response discarded, next req_addr=0x80000100, inst_pc=0x80000100, no stale inst_valid.
- Simultaneous redirect and response in S_WAIT: resp_valid and redirect_valid in the same cycle → inst_valid stays 0, next req_addr from redirect_pc, drop=0 (the following response is accepted).
- Fault: resp_err=1 → inst_fault=1, inst=0, inst_pc correct. The next fetch has inst_fault=0.
- Async reset mid-operation: drive rst=0 in S_WAIT between clock edges → immediately req_valid=0, inst_valid=0, fetch_cnt=0. After release, the request goes to 0x80000000.
